// File: rtl/mem_unit_pkg.sv
// Shared constants for the mem_unit data memory:
// funct3 codes, FSM states and the latency counter width.
package mem_unit_pkg;

    localparam int CNT_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/mem_align.sv
// Load lane extract/extend and store byte merge for mem_unit.
// Byte/halfword lanes exist only with MEM_UNIT_SUBWORD_EN defined.
module mem_align
    import mem_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            write_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      offset_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] word_i,
    output logic [XLEN-1:0] load_o,
    output logic [XLEN-1:0] store_o,
    output logic            err_o
);

`ifdef MEM_UNIT_SUBWORD_EN
    logic [4:0]      sh;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] bmask;
    logic [XLEN-1:0] hmask;

    assign sh    = {offset_i, 3'b000};
    assign lane  = word_i >> sh;
    assign bmask = XLEN'(8'hFF) << sh;
    assign hmask = XLEN'(16'hFFFF) << sh;

    always_comb begin
        load_o  = '0;
        store_o = word_i;
        err_o   = 1'b0;
        case (funct3_i)
            F3_B: begin
                if (write_i)
                    store_o = (word_i & ~bmask)
                            | (XLEN'(wdata_i[7:0]) << sh);
                else
                    load_o = {{(XLEN-8){lane[7]}}, lane[7:0]};
            end
            F3_H: begin
                err_o = offset_i[0];
                if (write_i)
                    store_o = (word_i & ~hmask)
                            | (XLEN'(wdata_i[15:0]) << sh);
                else
                    load_o = {{(XLEN-16){lane[15]}}, lane[15:0]};
            end
            F3_W: begin
                err_o = offset_i != 2'b00;
                if (write_i)
                    store_o = wdata_i;
                else
                    load_o = word_i;
            end
            F3_BU: begin
                err_o  = write_i;
                load_o = XLEN'(lane[7:0]);
            end
            F3_HU: begin
                err_o  = write_i | offset_i[0];
                load_o = XLEN'(lane[15:0]);
            end
            default: err_o = 1'b1;
        endcase
    end
`else
    always_comb begin
        load_o  = word_i;
        store_o = write_i ? wdata_i : word_i;
        err_o   = (funct3_i != F3_W) || (offset_i != 2'b00);
    end
`endif

endmodule

// File: rtl/mem_unit.sv
// Fixed-latency data memory with IDLE/WAIT/RESP handshake FSM.
// Define MEM_UNIT_SUBWORD_EN to enable byte/halfword accesses.
module mem_unit
    import mem_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err
);

    localparam int AW     = $clog2(DEPTH);
    localparam int IDX_HI = AW + 1;

    typedef logic [DEPTH-1:0][XLEN-1:0] mem_t;

    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < DEPTH; i++)
            m[i] = XLEN'(i);
        return m;
    endfunction

    mem_t mem_q = init_mem();

    state_e          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic            write_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            resp_valid_q;
    logic            resp_err_q;
    logic [XLEN-1:0] resp_rdata_q;

    logic            in_idle;
    logic            accept;
    logic            enter_resp;
    logic            cur_write;
    logic [2:0]      cur_funct3;
    logic [XLEN-1:0] cur_addr;
    logic [XLEN-1:0] cur_wdata;
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] hi_bits;
    logic            oor;
    logic            align_err;
    logic            err;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] store_data;

    assign in_idle   = state_q == IDLE;
    assign req_ready = in_idle & ~rst;
    assign accept    = req_valid & req_ready;

    // With zero latency the access completes on the accept edge itself.
    assign cur_write  = in_idle ? req_write  : write_q;
    assign cur_funct3 = in_idle ? req_funct3 : funct3_q;
    assign cur_addr   = in_idle ? req_addr   : addr_q;
    assign cur_wdata  = in_idle ? req_wdata  : wdata_q;

    assign enter_resp = ~rst & ((LATENCY == 0) ? accept
                      : (state_q == WAIT && cnt_q == '0));

    assign idx     = cur_addr[IDX_HI:2];
    assign hi_bits = cur_addr >> (IDX_HI + 1);
    assign oor     = |hi_bits;
    assign err     = align_err | oor;

    mem_align #(
        .XLEN(XLEN)
    ) u_align (
        .write_i (cur_write),
        .funct3_i(cur_funct3),
        .offset_i(cur_addr[1:0]),
        .wdata_i (cur_wdata),
        .word_i  (mem_q[idx]),
        .load_o  (load_data),
        .store_o (store_data),
        .err_o   (align_err)
    );

    always_ff @(posedge clk) begin
        if (enter_resp && cur_write && !err)
            mem_q[idx] <= store_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= enter_resp;
            resp_err_q   <= enter_resp & err;
            resp_rdata_q <= (enter_resp && !err && !cur_write)
                          ? load_data : '0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        write_q  <= req_write;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        if (LATENCY == 0) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0)
                        state_q <= RESP;
                    else
                        cnt_q <= cnt_q - CNT_W'(1);
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Mid-cycle reset must suppress a pending response immediately.
    assign resp_valid = resp_valid_q & ~rst;
    assign resp_err   = resp_err_q & ~rst;
    assign resp_rdata = rst ? '0 : resp_rdata_q;

endmodule

// File: tb/tb_mem_unit.sv
// Randomized bench for mem_unit against a byte-level reference model.
module tb_mem_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 128;
    localparam int LAT   = 2;

`ifdef MEM_UNIT_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [2:0]      req_funct3 = '0;
    logic [XLEN-1:0] req_addr = '0, req_wdata = '0;
    logic            resp_valid, resp_err;
    logic [XLEN-1:0] resp_rdata;

    logic            req_valid0 = 1'b0, req_ready0, req_write0 = 1'b0;
    logic [2:0]      req_funct30 = '0;
    logic [XLEN-1:0] req_addr0 = '0, req_wdata0 = '0;
    logic            resp_valid0, resp_err0;
    logic [XLEN-1:0] resp_rdata0;

    mem_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err)
    );

    mem_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0),
        .req_write(req_write0), .req_funct3(req_funct30),
        .req_addr(req_addr0), .req_wdata(req_wdata0),
        .resp_valid(resp_valid0), .resp_rdata(resp_rdata0),
        .resp_err(resp_err0)
    );

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] ref_mem [DEPTH];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void model(input bit w, input logic [2:0] f3,
                                  input logic [31:0] a,
                                  input logic [31:0] wd,
                                  output bit err,
                                  output logic [31:0] rd);
        int size, idx, off;
        bit sgn;
        logic [31:0] v;
        err = 1'b0; rd = '0; size = 0; sgn = 1'b0;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: size = 4;
            3'd4: if (!w) size = 1;
            3'd5: if (!w) size = 2;
            default: size = 0;
        endcase
        if (!SUBWORD && f3 != 3'd2) size = 0;
        if (size == 0 || a >= DEPTH * 4 || (a % size) != 0) begin
            err = 1'b1;
            return;
        end
        idx = int'(a / 4);
        off = int'(a % 4);
        if (w) begin
            for (int b = 0; b < size; b++)
                ref_mem[idx][8*(off+b) +: 8] = wd[8*b +: 8];
        end else begin
            v = '0;
            for (int b = 0; b < size; b++)
                v[8*b +: 8] = ref_mem[idx][8*(off+b) +: 8];
            if (sgn && size < 4 && v[8*size-1])
                for (int b = size; b < 4; b++)
                    v[8*b +: 8] = 8'hFF;
            rd = v;
        end
    endfunction

    task automatic access(input bit w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input string tag);
        bit eerr;
        bit got;
        logic [31:0] erd;
        int k;
        model(w, f3, a, wd, eerr, erd);
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, ".rdy"}, req_ready, 1);
        req_valid = 1'b1; req_write = w; req_funct3 = f3;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        got = 1'b0;
        for (int c = 1; c <= LAT + 4 && !got; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1;
                check({tag, ".lat"}, c, LAT + 1);
                check({tag, ".rdyr"}, req_ready, 0);
                check({tag, ".err"}, resp_err, eerr);
                check({tag, ".rdata"}, resp_rdata, erd);
            end else begin
                check({tag, ".busy"}, {req_ready, resp_err, resp_rdata}, 0);
            end
        end
        check({tag, ".resp"}, got, 1);
        @(negedge clk);
        check({tag, ".pulse"}, {resp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit w;
        logic [2:0] f3;
        logic [31:0] a;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.out", {req_ready, resp_valid, resp_err, resp_rdata}, 0);
        check("rst.out0", {req_ready0, resp_valid0, resp_err0, resp_rdata0}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst.rdy", req_ready, 1);
        check("rst.rdy0", req_ready0, 1);

        access(0, 3'd2, 32'h10, 0, "lw10");
        access(1, 3'd0, 32'h11, 32'hAB, "sb11");
        access(0, 3'd2, 32'h10, 0, "lw10b");
        access(0, 3'd0, 32'h11, 0, "lb11");
        access(0, 3'd4, 32'h11, 0, "lbu11");
        access(0, 3'd1, 32'h13, 0, "lh13");
        access(1, 3'd2, 32'h22, 32'hFFFFFFFF, "sw22");
        access(0, 3'd2, 32'h20, 0, "lw20");
        access(0, 3'd2, 32'h200, 0, "lw200");
        access(0, 3'd3, 32'h8, 0, "f3_011");

        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h0; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort.rst", {req_ready, resp_valid}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("abort.novalid", resp_valid, 0);
        end
        access(0, 3'd2, 32'h0, 0, "lw0");

        @(negedge clk);
        check("b2b.rdy0", req_ready0, 1);
        req_valid0 = 1'b1; req_write0 = 1'b0; req_funct30 = 3'd2;
        req_addr0 = 32'h20;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("b2b.valid", resp_valid0, k % 2);
            check("b2b.rdy", req_ready0, (k % 2) == 0);
            if (resp_valid0)
                check("b2b.data", {resp_err0, resp_rdata0}, 33'h8);
        end
        req_valid0 = 1'b0;

        for (int i = 0; i < 150; i++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0)
                a = $urandom();
            else
                a = 32'($urandom_range(0, DEPTH * 4 - 1));
            if ($urandom_range(0, 1) == 1)
                a[1:0] = 2'b00;
            access(w, f3, a, $urandom(), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_unit.md
MEM_UNIT -- requirements
Module: mem_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width in bits.
REQ-002 SHALL have parameter DEPTH, default 128, number of XLEN-bit words; power of two, at least 2.
REQ-003 SHALL have parameter LATENCY, default 2, wait cycles between acceptance and response; range 0..15.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1 bit: request present.
REQ-007 SHALL have port req_ready, output, 1 bit: unit can accept a request.
REQ-008 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-009 SHALL have port req_funct3, input, 3 bits: RISC-V access size/sign code.
REQ-010 SHALL have port req_addr, input, XLEN bits: byte address.
REQ-011 SHALL have port req_wdata, input, XLEN bits: store data, right-aligned.
REQ-012 SHALL have port resp_valid, output, 1 bit: one-cycle response pulse.
REQ-013 SHALL have port resp_rdata, output, XLEN bits: load result; 0 for stores and errors.
REQ-014 SHALL have port resp_err, output, 1 bit: misaligned, illegal funct3 or out-of-range access.

Function
REQ-015 SHALL use a state machine with states IDLE, WAIT and RESP.
REQ-016 SHALL drive req_ready = 1 only in IDLE with rst low; a request is accepted when req_valid and req_ready are both 1.
REQ-017 SHALL, on acceptance, register write, funct3, addr and wdata, then go to WAIT if LATENCY > 0, else to RESP.
REQ-018 SHALL stay in WAIT exactly LATENCY cycles, counted by a 4-bit down-counter, then go to RESP.
REQ-019 SHALL assert resp_valid for exactly one cycle in RESP, LATENCY+1 cycles after the acceptance edge, then return to IDLE; maximum throughput is one access per LATENCY+2 cycles.
REQ-020 SHALL decode loads as funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, sign- or zero-extending the selected lane to XLEN.
REQ-021 SHALL decode stores as funct3 000 SB, 001 SH, 010 SW, merging only the addressed bytes and leaving all other bytes unchanged.
REQ-022 SHALL use word index req_addr[log2(DEPTH)+1:2]; any set address bit above that range SHALL be an out-of-range error.
REQ-023 SHALL flag an error when a halfword access has addr[0] != 0, a word access has addr[1:0] != 0, funct3 is any other code, or the access is out of range; the error response gives resp_err = 1 and resp_rdata = 0, and the array is not written.
REQ-024 SHALL commit a store on the edge entering RESP; load data SHALL be read from the array on that same edge.
REQ-025 SHALL initialise array word i to value i at time zero; rst SHALL NOT alter array contents.
REQ-026 SHALL hold resp_rdata and resp_err at 0 whenever resp_valid is 0.

Reset
REQ-027 SHALL, while rst is high, force IDLE, req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0 and counter = 0.
REQ-028 SHALL, when rst is asserted in WAIT or RESP, abort the access: an uncommitted store is discarded and no resp_valid is produced.
REQ-029 SHALL assert req_ready in the first cycle after rst falls.

Configuration
REQ-030 SHALL support macro MEM_UNIT_SUBWORD_EN; when defined, byte and halfword accesses are supported per REQ-020 and REQ-021.
REQ-031 SHALL, when MEM_UNIT_SUBWORD_EN is undefined, support only LW and SW; every other funct3 SHALL be an error per REQ-023, and no lane-select logic is synthesised.

Structure
REQ-032 SHALL place funct3 constants, the state enumeration and the LATENCY counter width in shared package mem_unit_pkg.
REQ-033 SHALL implement load lane extraction/extension and store byte merge in one combinational sub-module, mem_align.

Verification
REQ-034 SHALL cover: LATENCY=2, LW addr 0x10 -> req_ready low 3 cycles, resp_valid on 3rd cycle after accept, rdata 0x00000004, err 0.
REQ-035 SHALL cover: SB 0xAB at 0x11, then LW 0x10 -> 0x0000AB04; LB 0x11 -> 0xFFFFFFAB; LBU 0x11 -> 0x000000AB.
REQ-036 SHALL cover: LH at 0x13 -> resp_err 1, rdata 0; SW 0xFFFFFFFF at 0x22 -> resp_err 1; LW 0x20 -> 0x00000008.
REQ-037 SHALL cover: DEPTH=128, LW 0x200 -> resp_err 1; funct3 011 -> resp_err 1.
REQ-038 SHALL cover: SW 0x55 at 0x0, rst pulsed during WAIT -> no resp_valid; then LW 0x0 -> 0x00000000.
REQ-039 SHALL cover: req_valid held high for back-to-back LW, LATENCY=0 -> accepts every 2nd cycle, resp_valid pulses on alternate cycles.
